// File: rtl/fir_decimator.sv
// fir_decimator: keeps every DECIM-th valid sample, applies a saturating
// power-of-two gain and buffers the results in a small output FIFO.
module fir_decimator #(
  parameter int DECIM      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(DECIM),
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   din,
  input  logic          din_valid,
  input  logic [1:0]    gain_shift,
  output logic [15:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [LW-1:0] level,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CW-1:0] phase_q, phase_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   dout_q, dout_d;
  logic          dval_q, dval_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic signed [18:0] ext_w;
  logic signed [18:0] shl_w;
  logic [15:0]        gained_w;
  logic               sel_w;
  logic               full_w;
  logic               pop_w;
  logic               push_w;
  logic               drop_w;

  // Sample select and saturating gain
  always_comb begin
    sel_w = din_valid && (phase_q == CW'(DECIM - 1));
    ext_w = {{3{din[15]}}, din};
    shl_w = ext_w <<< gain_shift;
    gained_w = shl_w[15:0];
    if (shl_w[18:15] != {4{shl_w[18]}}) begin
      gained_w = shl_w[18] ? 16'h8000 : 16'h7fff;
    end
  end

  // FIFO control, next head value and overflow flag
  always_comb begin
    full_w  = (level_q == LW'(FIFO_DEPTH));
    pop_w   = dval_q && dout_ready;
    push_w  = sel_w && (!full_w || pop_w);
    drop_w  = sel_w && full_w && !pop_w;
    phase_d = phase_q;
    if (din_valid) begin
      phase_d = sel_w ? '0 : phase_q + CW'(1);
    end
    wptr_d  = push_w ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_w ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    unique case ({push_w, pop_w})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    dval_d = (level_d != '0);
    dout_d = '0;
    if (dval_d) begin
      if (push_w && (level_q - LW'(pop_w)) == '0) begin
        dout_d = gained_w;
      end else begin
        dout_d = mem_q[rptr_d];
      end
    end
    ovf_d = ovf_q;
    if (drop_w) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_w) begin
      mem_q[wptr_q] <= gained_w;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed checks of decimation, gain saturation,
// FIFO full/overflow handling and asynchronous reset.
module tb_fir_decimator;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        din_valid;
  logic [1:0]  gain_shift;
  logic        clr;
  logic        rdy4, rdy2;
  logic [15:0] d4, d2;
  logic        v4, v2;
  logic [2:0]  l4, l2;
  logic        o4, o2;

  int n_run;
  int n_fail;

  fir_decimator #(.DECIM(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .gain_shift(gain_shift), .dout(d4), .dout_valid(v4),
    .dout_ready(rdy4), .level(l4), .overflow(o4),
    .clr_overflow(clr)
  );

  fir_decimator #(.DECIM(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .gain_shift(gain_shift), .dout(d2), .dout_valid(v2),
    .dout_ready(rdy2), .level(l2), .overflow(o2),
    .clr_overflow(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    din_valid = 1'b0;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  int cnt;
  int sat_in [6];
  int sat_g  [6];
  int sat_ex [6];

  initial begin
    n_run = 0;
    n_fail = 0;
    din = '0;
    din_valid = 1'b0;
    gain_shift = 2'd0;
    clr = 1'b0;
    rdy4 = 1'b1;
    rdy2 = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_level", int'(l4), 0);
    chk("rst_valid", int'(v4), 0);
    chk("rst_dout", int'(d4), 0);
    chk("rst_ovf", int'(o4), 0);
    #2 rst_n = 1'b1;
    cyc();

    // Decimation by 4, every cycle valid
    for (int i = 1; i <= 12; i++) begin
      din = 16'(i);
      din_valid = 1'b1;
      cyc();
      chk("dec_valid", int'(v4), (i % 4 == 0) ? 1 : 0);
      chk("dec_dout", int'($signed(d4)), (i % 4 == 0) ? i : 0);
      chk("dec_level", int'(l4), (i % 4 == 0) ? 1 : 0);
    end

    // Gaps in din_valid
    pulse_rst();
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        cnt++;
        din = 16'(cnt);
        din_valid = 1'b1;
      end else begin
        din = 16'd999;
        din_valid = 1'b0;
      end
      cyc();
      if (k % 2 == 0 && cnt % 4 == 0) begin
        chk("gap_valid", int'(v4), 1);
        chk("gap_dout", int'($signed(d4)), cnt);
      end else begin
        chk("gap_idle", int'(v4), 0);
      end
    end

    // Saturating gain
    sat_in = '{5000, -5000, -4096, 100, -16384, 20000};
    sat_g  = '{3, 3, 3, 3, 1, 1};
    sat_ex = '{32767, -32768, -32768, 800, -32768, 32767};
    pulse_rst();
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < 3; j++) begin
        din = 16'd7;
        din_valid = 1'b1;
        gain_shift = 2'd0;
        cyc();
      end
      din = 16'(sat_in[s]);
      gain_shift = 2'(sat_g[s]);
      cyc();
      chk("sat_valid", int'(v4), 1);
      chk("sat_dout", int'($signed(d4)), sat_ex[s]);
    end
    gain_shift = 2'd0;

    // Full FIFO and overflow with DECIM=2
    pulse_rst();
    rdy2 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      din = 16'(i);
      din_valid = 1'b1;
      cyc();
      if (i == 8) begin
        chk("full_level", int'(l2), 4);
        chk("full_ovf0", int'(o2), 0);
      end
    end
    chk("ovf_level", int'(l2), 4);
    chk("ovf_set", int'(o2), 1);
    chk("ovf_head", int'($signed(d2)), 2);
    din_valid = 1'b0;
    rdy2 = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      chk("drain_valid", int'(v2), 1);
      chk("drain_dout", int'($signed(d2)), 2 * j);
      cyc();
    end
    chk("drain_empty", int'(v2), 0);
    chk("drain_dout0", int'($signed(d2)), 0);
    chk("drain_level", int'(l2), 0);
    chk("ovf_sticky", int'(o2), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf_clr", int'(o2), 0);

    // Drop coinciding with clear: set wins
    rdy2 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      din = 16'(i);
      din_valid = 1'b1;
      clr = (i == 10);
      cyc();
    end
    chk("ovf_setwins", int'(o2), 1);
    din_valid = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf_clr2", int'(o2), 0);

    // Full with simultaneous pop and push
    din = 16'd11;
    din_valid = 1'b1;
    cyc();
    din = 16'd12;
    rdy2 = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("fpp_level", int'(l2), 4);
    chk("fpp_ovf", int'(o2), 0);
    for (int j = 0; j < 4; j++) begin
      chk("fpp_dout", int'($signed(d2)), (j == 3) ? 12 : 4 + 2 * j);
      cyc();
    end
    chk("fpp_empty", int'(v2), 0);

    // Asynchronous reset mid-stream
    pulse_rst();
    rdy4 = 1'b0;
    rdy2 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      din = 16'(i);
      din_valid = 1'b1;
      cyc();
    end
    din_valid = 1'b0;
    chk("pre_level", int'(l4), 3);
    chk("pre_ovf2", int'(o2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_level", int'(l4), 0);
    chk("mrst_valid", int'(v4), 0);
    chk("mrst_dout", int'(d4), 0);
    chk("mrst_ovf", int'(o2), 0);
    #1 rst_n = 1'b1;
    rdy4 = 1'b1;
    for (int i = 101; i <= 104; i++) begin
      din = 16'(i);
      din_valid = 1'b1;
      cyc();
      chk("post_valid", int'(v4), (i == 104) ? 1 : 0);
    end
    chk("post_dout", int'($signed(d4)), 104);
    din_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
